// File: rtl/seg7_pkg.sv
// Shared segment-pattern constants, packer state encoding and default digit
// count. Also used by the octal-to-7-segment encoder.
package seg7_pkg;

    localparam int NDIG_DEFAULT = 5;

    // Active-low patterns, bit order gfedcba (bit 6 = g).
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } pack_state_t;

    // Encoder direction: octal digit to segment pattern.
    function automatic logic [6:0] oct_to_seg(input logic [2:0] digit);
        logic [6:0] seg;
        case (digit)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            3'd7:    seg = SEG_7;
            default: seg = SEG_0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_oct_packer_if.sv
// Segment-in / packed-word-out handshake bundle for seg7_oct_packer.
interface seg7_oct_packer_if #(
    parameter int NDIG = 5
);
    logic [6:0]        seg_i;
    logic              seg_valid_i;
    logic              seg_ready_o;
    logic [3*NDIG-1:0] word_o;
    logic              word_valid_o;
    logic              word_ready_i;
    logic              err_o;
    logic [7:0]        err_cnt_o;

    // Producer/consumer side (testbench or upstream logic).
    modport master (
        output seg_i, seg_valid_i, word_ready_i,
        input  seg_ready_o, word_o, word_valid_o, err_o, err_cnt_o
    );

    // Packer side.
    modport slave (
        input  seg_i, seg_valid_i, word_ready_i,
        output seg_ready_o, word_o, word_valid_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/seg7_to_oct.sv
// Combinational decode of an active-low 7-segment pattern to an octal digit.
// Only the eight canonical patterns are legal; anything else flags illegal.
module seg7_to_oct
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [2:0] digit_o,
    output logic       legal_o
);

    // Exact-match lookup of the eight digit patterns.
    always_comb begin
        digit_o = 3'd0;
        legal_o = 1'b1;
        case (seg_i)
            SEG_0:   digit_o = 3'd0;
            SEG_1:   digit_o = 3'd1;
            SEG_2:   digit_o = 3'd2;
            SEG_3:   digit_o = 3'd3;
            SEG_4:   digit_o = 3'd4;
            SEG_5:   digit_o = 3'd5;
            SEG_6:   digit_o = 3'd6;
            SEG_7:   digit_o = 3'd7;
            default: begin
                digit_o = 3'd0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_oct_packer.sv
// Packs NDIG decoded octal digits into one word, first digit in the MS bits.
// Illegal patterns drop the partial word, pulse err_o and bump a saturating
// error counter. Outputs come straight from registers.
module seg7_oct_packer
    import seg7_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    seg7_oct_packer_if.slave   bus
);

    localparam int W     = 3 * NDIG;
    localparam int CNT_W = $clog2(NDIG + 1);

    pack_state_t      r_state;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    pack_state_t      w_state_nxt;
    logic [W-1:0]     w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_err_nxt;
    logic [7:0]       w_err_cnt_nxt;

    logic [2:0]       w_digit;
    logic             w_legal;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [W-1:0]     w_acc_shift;

    seg7_to_oct u_dec (
        .seg_i   (bus.seg_i),
        .digit_o (w_digit),
        .legal_o (w_legal)
    );

    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_acc_shift = (r_acc << 2'd3) | W'(w_digit);

    // Next-state, accumulator, digit count and error bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        case (r_state)
            ST_COLLECT: begin
                if (bus.seg_valid_i) begin
                    if (w_legal) begin
                        w_acc_nxt = w_acc_shift;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(NDIG)) begin
                            w_state_nxt = ST_FULL;
                        end else begin
                            w_state_nxt = ST_COLLECT;
                        end
                    end else begin
                        // Partial word is dropped on a bad pattern.
                        w_acc_nxt = '0;
                        w_cnt_nxt = '0;
                        w_err_nxt = 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                            w_err_cnt_nxt = r_err_cnt + 8'd1;
                        end else begin
                            w_err_cnt_nxt = r_err_cnt;
                        end
                    end
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_FULL: begin
                // Inputs are ignored here; word held until consumed.
                if (bus.word_ready_i) begin
                    w_state_nxt = ST_COLLECT;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_COLLECT;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign bus.seg_ready_o  = (r_state == ST_COLLECT);
    assign bus.word_valid_o = (r_state == ST_FULL);
    assign bus.word_o       = r_acc;
    assign bus.err_o        = r_err;
    assign bus.err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_seg7_oct_packer.sv
// Directed table-driven bench for seg7_oct_packer plus hand-written reset,
// error-saturation and randomly gapped scoreboard sequences.
module tb_seg7_oct_packer;
    import seg7_pkg::*;

    localparam int ND = 5;

    typedef struct {
        logic [6:0]  seg;
        logic        v;
        logic        wr;
        logic        e_ready;
        logic        e_wv;
        logic [14:0] e_word;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    seg7_oct_packer_if #(.NDIG(ND)) bus ();

    seg7_oct_packer #(.NDIG(ND)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] seg, input logic v, input logic wr,
                       input logic er, input logic ewv, input logic [14:0] ew,
                       input logic ee, input logic [7:0] ec);
        vec_t t;
        t.seg = seg; t.v = v; t.wr = wr; t.e_ready = er; t.e_wv = ewv;
        t.e_word = ew; t.e_err = ee; t.e_cnt = ec;
        tbl.push_back(t);
    endtask

    task automatic chk_all(input string tag, input logic er, input logic ewv,
                           input logic [14:0] ew, input logic ee, input logic [7:0] ec);
        chk({tag, ".ready"},   32'(bus.seg_ready_o),  32'(er));
        chk({tag, ".wvalid"},  32'(bus.word_valid_o), 32'(ewv));
        chk({tag, ".word"},    32'(bus.word_o),       32'(ew));
        chk({tag, ".err"},     32'(bus.err_o),        32'(ee));
        chk({tag, ".err_cnt"}, 32'(bus.err_cnt_o),    32'(ec));
    endtask

    task automatic send(input logic [2:0] d);
        bus.seg_i = oct_to_seg(d);
        bus.seg_valid_i = 1'b1;
        tick();
    endtask

    logic [14:0] exp_q[$];
    logic [14:0] part_word;
    int          part_cnt;
    int          words;
    int          cyc;
    logic [2:0]  rd;

    initial begin
        bus.seg_i = 7'd0;
        bus.seg_valid_i = 1'b0;
        bus.word_ready_i = 1'b0;

        // Back-to-back 0..4, held FULL while offering 7, then release.
        add(SEG_0, 1'b1, 1'b0, 1'b1, 1'b0, 15'o0,     1'b0, 8'd0);
        add(SEG_1, 1'b1, 1'b0, 1'b1, 1'b0, 15'o1,     1'b0, 8'd0);
        add(SEG_2, 1'b1, 1'b0, 1'b1, 1'b0, 15'o12,    1'b0, 8'd0);
        add(SEG_3, 1'b1, 1'b0, 1'b1, 1'b0, 15'o123,   1'b0, 8'd0);
        add(SEG_4, 1'b1, 1'b0, 1'b0, 1'b1, 15'o01234, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++)
            add(SEG_7, 1'b1, 1'b0, 1'b0, 1'b1, 15'o01234, 1'b0, 8'd0);
        add(SEG_7, 1'b1, 1'b1, 1'b1, 1'b0, 15'o0,     1'b0, 8'd0);
        // 5,6, illegal, then 5,6,7,7,7.
        add(SEG_5,   1'b1, 1'b0, 1'b1, 1'b0, 15'o5,     1'b0, 8'd0);
        add(SEG_6,   1'b1, 1'b0, 1'b1, 1'b0, 15'o56,    1'b0, 8'd0);
        add(7'h7F,   1'b1, 1'b0, 1'b1, 1'b0, 15'o0,     1'b1, 8'd1);
        add(SEG_5,   1'b1, 1'b0, 1'b1, 1'b0, 15'o5,     1'b0, 8'd1);
        add(SEG_6,   1'b1, 1'b0, 1'b1, 1'b0, 15'o56,    1'b0, 8'd1);
        add(SEG_7,   1'b1, 1'b0, 1'b1, 1'b0, 15'o567,   1'b0, 8'd1);
        add(SEG_7,   1'b1, 1'b0, 1'b1, 1'b0, 15'o5677,  1'b0, 8'd1);
        add(SEG_7,   1'b1, 1'b0, 1'b0, 1'b1, 15'o56777, 1'b0, 8'd1);
        add(SEG_0,   1'b0, 1'b1, 1'b1, 1'b0, 15'o0,     1'b0, 8'd1);
        // word_ready in COLLECT has no effect; idle cycles hold the accumulator.
        add(SEG_3,   1'b0, 1'b1, 1'b1, 1'b0, 15'o0,     1'b0, 8'd1);
        add(SEG_3,   1'b1, 1'b1, 1'b1, 1'b0, 15'o3,     1'b0, 8'd1);
        add(SEG_4,   1'b0, 1'b1, 1'b1, 1'b0, 15'o3,     1'b0, 8'd1);

        // Reset state.
        tick(); tick();
        rst = 1'b0;
        #1;
        chk_all("reset", 1'b1, 1'b0, 15'o0, 1'b0, 8'd0);

        foreach (tbl[i]) begin
            bus.seg_i = tbl[i].seg;
            bus.seg_valid_i = tbl[i].v;
            bus.word_ready_i = tbl[i].wr;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_wv,
                    tbl[i].e_word, tbl[i].e_err, tbl[i].e_cnt);
        end

        // Reset mid-word (with a digit offered) wins; then 7,6,5,4,3.
        bus.word_ready_i = 1'b0;
        send(3'd1); send(3'd2); send(3'd3);
        chk("pre_rst.word", 32'(bus.word_o), 32'(15'o3123));
        rst = 1'b1;
        bus.seg_i = SEG_4;
        tick();
        rst = 1'b0;
        bus.seg_valid_i = 1'b0;
        chk_all("midrst", 1'b1, 1'b0, 15'o0, 1'b0, 8'd0);
        send(3'd7); send(3'd6); send(3'd5); send(3'd4); send(3'd3);
        bus.seg_valid_i = 1'b0;
        chk_all("after_rst", 1'b0, 1'b1, 15'o76543, 1'b0, 8'd0);
        bus.word_ready_i = 1'b1;
        tick();
        bus.word_ready_i = 1'b0;
        chk("release.ready", 32'(bus.seg_ready_o), 32'd1);

        // 260 illegal patterns: counter saturates, err_o on each, no word.
        for (int i = 0; i < 260; i++) begin
            bus.seg_i = 7'b0000000;
            bus.seg_valid_i = 1'b1;
            tick();
            chk("ill.err", 32'(bus.err_o), 32'd1);
            chk("ill.wvalid", 32'(bus.word_valid_o), 32'd0);
            chk("ill.cnt", 32'(bus.err_cnt_o), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        bus.seg_valid_i = 1'b0;
        tick();
        chk("ill.err_end", 32'(bus.err_o), 32'd0);
        chk("ill.cnt_end", 32'(bus.err_cnt_o), 32'd255);

        // Randomly gapped traffic against a transaction scoreboard.
        part_word = 15'd0;
        part_cnt = 0;
        words = 0;
        cyc = 0;
        while (words < 100 && cyc < 20000) begin
            rd = 3'($urandom_range(0, 7));
            bus.seg_valid_i = 1'($urandom_range(0, 1));
            bus.word_ready_i = 1'($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) bus.seg_i = 7'h7F;
            else bus.seg_i = oct_to_seg(rd);
            if (bus.seg_valid_i && bus.seg_ready_o) begin
                if (bus.seg_i == 7'h7F) begin
                    part_word = 15'd0;
                    part_cnt = 0;
                end else begin
                    part_word = {part_word[11:0], rd};
                    part_cnt++;
                    if (part_cnt == ND) begin
                        exp_q.push_back(part_word);
                        part_word = 15'd0;
                        part_cnt = 0;
                    end
                end
            end
            if (bus.word_valid_o && bus.word_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rand_extra: got word 'o%0o, expected none", bus.word_o);
                end else begin
                    chk($sformatf("rand_word%0d", words), 32'(bus.word_o), 32'(exp_q.pop_front()));
                end
                words++;
            end
            tick();
            cyc++;
        end
        bus.seg_valid_i = 1'b0;
        bus.word_ready_i = 1'b0;
        chk("rand_words", 32'(words), 32'd100);
        chk("rand_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_oct_packer.md
SEG7_OCT_PACKER -- requirements
Module: seg7_oct_packer

Interface
REQ-001 Parameter NDIG, default 5, SHALL set the number of octal digits packed per word (word width 3*NDIG).
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 seg_i  input  7  active-low segment pattern, bit order gfedcba (bit 6 = g).
REQ-005 seg_valid_i  input  1  seg_i holds a pattern offered for transfer.
REQ-006 seg_ready_o  output  1  block can accept a pattern this cycle.
REQ-007 word_o  output  3*NDIG  packed octal word; first-accepted digit in the MS 3 bits.
REQ-008 word_valid_o  output  1  word_o is complete and held stable.
REQ-009 word_ready_i  input  1  consumer accepts word_o.
REQ-010 err_o  output  1  one-cycle pulse on acceptance of an illegal pattern.
REQ-011 err_cnt_o  output  8  count of illegal patterns, saturating at 255.

Function
REQ-012 Legal patterns SHALL be exactly: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000; all other 120 codes are illegal.
REQ-013 Transfer SHALL occur on a cycle with seg_valid_i && seg_ready_o; output handshake completes on word_valid_o && word_ready_i.
REQ-014 FSM SHALL have two states: COLLECT (seg_ready_o=1, word_valid_o=0) and FULL (seg_ready_o=0, word_valid_o=1).
REQ-015 In COLLECT, a legal transfer SHALL shift the accumulator left by 3 bits, insert the decoded digit in bits [2:0], and increment digit count.
REQ-016 A legal transfer that makes digit count equal NDIG SHALL move to FULL; word_valid_o rises the cycle after that transfer (1-cycle latency).
REQ-017 word_o SHALL be stable throughout FULL; seg_valid_i is ignored in FULL.
REQ-018 In FULL, word_ready_i=1 SHALL return to COLLECT with count and accumulator cleared; seg_ready_o is high the following cycle (no same-cycle pass-through).
REQ-019 word_ready_i while in COLLECT SHALL have no effect.
REQ-020 An illegal transfer SHALL discard the pattern, clear accumulator and count (partial word dropped), pulse err_o next cycle, and increment err_cnt_o unless it is 255.
REQ-021 err_cnt_o SHALL hold at 255 on further illegal patterns and clear only on reset.
REQ-022 word_o outside FULL SHALL show the live accumulator (informational only).

Reset
REQ-023 rst_i SHALL have priority over all activity, including mid-word and in FULL: state COLLECT, accumulator 0, count 0, word_o 0, word_valid_o 0, seg_ready_o 1 in the cycle after reset, err_o 0, err_cnt_o 0.

Structure
REQ-024 A shared package seg7_pkg SHALL hold the eight segment-pattern constants, the state encoding, and NDIG default, shared with the existing octal-to-7-segment encoder.
REQ-025 Decoding SHALL live in one combinational sub-module seg7_to_oct (7-bit pattern in; 3-bit digit and legal flag out); FSM, accumulator and counters stay in seg7_oct_packer.

Verification
REQ-026 Send patterns for 0,1,2,3,4 back-to-back with seg_valid_i held high -> word_valid_o high one cycle after 5th transfer, word_o = 15'o01234, seg_ready_o low.
REQ-027 Hold word_ready_i low 10 cycles in FULL while driving pattern 7 -> word_o stays 15'o01234, no digit absorbed; then word_ready_i=1 -> next cycle COLLECT, seg_ready_o=1.
REQ-028 Send 5,6, then 1111111, then 5,6,7,7,7 -> err_o one-cycle pulse, err_cnt_o=1, final word_o = 15'o56777.
REQ-029 Send 3 digits then assert rst_i one cycle -> all outputs at reset values; next 5 digits 7,6,5,4,3 produce 15'o76543.
REQ-030 Send 260 illegal patterns (0000000) -> err_cnt_o = 255, err_o pulses on each, no word_valid_o.
REQ-031 Randomly gapped seg_valid_i and word_ready_i over 100 words -> every packed word matches scoreboard; no digit lost or duplicated.
